// File: rtl/i2s_tx.sv
// i2s_tx: Philips I2S serializer; BCLK/LRCK from the audio divider are sampled as data in the clk_12Mhz domain.
// One stereo pair per frame through a 1-deep holding register; each channel left-justified in its slot.
module i2s_tx #(
   parameter int DATA_WIDTH = 16,
   parameter int SLOT_WIDTH = 16
) (
   input  logic                  clk_12Mhz,
   input  logic                  reset,
   input  logic                  bclk,
   input  logic                  lrck,
   input  logic [DATA_WIDTH-1:0] sample_l,
   input  logic [DATA_WIDTH-1:0] sample_r,
   input  logic                  sample_valid,
   output logic                  sample_ready,
   output logic                  sdata,
   output logic                  locked,
   output logic                  frame_start,
   output logic                  underrun,
   output logic                  sync_err
);
   localparam int FW = 2 * SLOT_WIDTH;
   localparam int CW = $clog2(FW);
   localparam logic [0:0] UNLOCKED = 1'b0;
   localparam logic [0:0] RUN = 1'b1;
   logic [0:0] state;
   logic bclk_q, lrck_q, hold_full;
   logic [FW-1:0] hold, sr;
   logic [CW-1:0] bit_cnt;
   logic [SLOT_WIDTH-1:0] slot_l, slot_r;
   logic bfall, lfall, lrise, accept, run;
   assign bfall = bclk_q & ~bclk;
   assign lfall = lrck_q & ~lrck;
   assign lrise = ~lrck_q & lrck;
   assign run = state == RUN;
   assign locked = run;
   assign sample_ready = ~reset & ~hold_full;
   assign accept = sample_valid & sample_ready;
   assign slot_l = SLOT_WIDTH'(sample_l) << (SLOT_WIDTH - DATA_WIDTH);
   assign slot_r = SLOT_WIDTH'(sample_r) << (SLOT_WIDTH - DATA_WIDTH);
   always_ff @(posedge clk_12Mhz) begin
      if (reset) begin
         state       <= UNLOCKED;
         bclk_q      <= 1'b0;
         lrck_q      <= 1'b0;
         hold_full   <= 1'b0;
         hold        <= '0;
         sr          <= '0;
         bit_cnt     <= '0;
         sdata       <= 1'b0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         bclk_q      <= bclk;
         lrck_q      <= lrck;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
         sync_err    <= 1'b0;
         if (accept) begin
            hold      <= {slot_l, slot_r};
            hold_full <= 1'b1;
         end
         // sr is all-zero while unlocked, so the locking edge still drives sdata low
         if (bfall & lfall) begin
            sdata       <= sr[FW-1];
            sr          <= hold_full ? hold : '0;
            underrun    <= ~hold_full;
            sync_err    <= run & (bit_cnt != '0);
            bit_cnt     <= CW'(1);
            frame_start <= 1'b1;
            state       <= RUN;
            if (hold_full) hold_full <= 1'b0;
         end else if (bfall & run) begin
            sdata    <= sr[FW-1];
            sr       <= sr << 1;
            bit_cnt  <= (bit_cnt == CW'(FW - 1)) ? '0 : bit_cnt + 1'b1;
            sync_err <= lrise & (bit_cnt != CW'(SLOT_WIDTH));
         end
      end
   end
endmodule
